rr_ring_arbiter: RTL and testbench



---
 rtl/rr_arb_pkg.sv | 26 ++
 rtl/rr_ring_pick.sv | 21 ++
 rtl/rr_ring_arbiter.sv | 105 ++++++++++
 tb/tb_rr_ring_arbiter.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/rr_arb_pkg.sv
// rtl/rr_arb_pkg.sv - shared types, reset pointer and one-hot helpers for rr_ring_arbiter
package rr_arb_pkg;

  localparam int MAX_N = 16;

  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} arb_state_e;

  localparam logic [MAX_N-1:0] PTR_RST = MAX_N'(1);

  // Rotate the low n bits of v left by one; bit n-1 wraps to bit 0.
  function automatic logic [MAX_N-1:0] rotl1(input logic [MAX_N-1:0] v, input int n);
    logic [MAX_N-1:0] mask;
    mask = (MAX_N'(1) << n) - MAX_N'(1);
    return ((v << 1) | (v >> (n - 1))) & mask;
  endfunction

  function automatic logic [3:0] onehot2bin(input logic [MAX_N-1:0] v);
    logic [3:0] b;
    b = '0;
    for (int i = 0; i < MAX_N; i++) begin
      if (v[i]) b = b | 4'(i);
    end
    return b;
  endfunction

endpackage

// File: rtl/rr_ring_pick.sv
// rtl/rr_ring_pick.sv - combinational winner select: first set req at or above ptr, wrapping
module rr_ring_pick #(
  parameter int N = 4
) (
  input  logic [N-1:0] req_i,
  input  logic [N-1:0] ptr_i,
  output logic [N-1:0] gnt_o
);

  localparam logic [N-1:0]   ONE  = N'(1);
  localparam logic [2*N-1:0] ONE2 = (2*N)'(1);

  logic [2*N-1:0] masked;
  logic [2*N-1:0] lowest;

  // Lower copy only keeps bits at/above ptr; upper copy covers the wrap.
  assign masked = {req_i, req_i & ~(ptr_i - ONE)};
  assign lowest = masked & (~masked + ONE2);
  assign gnt_o  = lowest[N-1:0] | lowest[2*N-1:N];

endmodule

// File: rtl/rr_ring_arbiter.sv
// rtl/rr_ring_arbiter.sv - round-robin one-hot ring arbiter; optional grant timeout via RR_ARB_TIMEOUT_EN
module rr_ring_arbiter
  import rr_arb_pkg::*;
#(
  parameter int N        = 4,
  parameter int MAX_HOLD = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [N-1:0]         req,
  output logic [N-1:0]         gnt,
  output logic                 gnt_valid,
  output logic [$clog2(N)-1:0] gnt_id,
  output logic                 timeout
);

  localparam int IDW = $clog2(N);

  arb_state_e     state_q;
  logic [N-1:0]   gnt_q, ptr_q, ptr_d, gnt_d;
  logic [N-1:0]   pick_req, pick_ptr;
  logic           valid_q;
  logic [IDW-1:0] id_q;
  logic           held, revoke, end_grant;

  assign held      = |(req & gnt_q);
  assign ptr_d     = N'(rotl1(MAX_N'(gnt_q), N));
  assign end_grant = !held || revoke;

  // While granting, select against the post-rotation pointer with the holder masked out.
  always_comb begin
    pick_ptr = ptr_q;
    pick_req = req;
    if (state_q == GRANT) begin
      pick_ptr = ptr_d;
      pick_req = req & ~gnt_q;
    end
  end

  rr_ring_pick #(.N(N)) u_pick (
    .req_i (pick_req),
    .ptr_i (pick_ptr),
    .gnt_o (gnt_d)
  );

`ifdef RR_ARB_TIMEOUT_EN
  localparam int HW = $clog2(MAX_HOLD + 1);

  logic [HW-1:0] hold_q;
  logic          timeout_q;

  assign revoke  = held && (hold_q == HW'(MAX_HOLD - 1));
  assign timeout = timeout_q;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      hold_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= (state_q == GRANT) && revoke;
      if ((state_q == GRANT) && !end_grant) hold_q <= hold_q + HW'(1);
      else                                  hold_q <= '0;
    end
  end
`else
  assign revoke  = 1'b0;
  assign timeout = (MAX_HOLD < 0);
`endif

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      ptr_q   <= N'(PTR_RST);
      valid_q <= 1'b0;
      id_q    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (|gnt_d) begin
            state_q <= GRANT;
            gnt_q   <= gnt_d;
            valid_q <= 1'b1;
            id_q    <= IDW'(onehot2bin(MAX_N'(gnt_d)));
          end
        end
        GRANT: begin
          if (end_grant) begin
            ptr_q   <= ptr_d;
            gnt_q   <= gnt_d;
            valid_q <= |gnt_d;
            id_q    <= IDW'(onehot2bin(MAX_N'(gnt_d)));
            if (!(|gnt_d)) state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign gnt       = gnt_q;
  assign gnt_valid = valid_q;
  assign gnt_id    = id_q;

endmodule

// File: tb/tb_rr_ring_arbiter.sv
// tb/tb_rr_ring_arbiter.sv - directed and random checks of rr_ring_arbiter against a behavioural model
module tb_rr_ring_arbiter;

  localparam int N  = 4;
  localparam int MH = 8;
`ifdef RR_ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         reset_n;
  logic [N-1:0] req;
  logic [N-1:0] gnt;
  logic         gnt_valid;
  logic [1:0]   gnt_id;
  logic         timeout;

  int checks   = 0;
  int failures = 0;

  int m_owner;
  int m_ptr;
  int m_hold;
  bit m_to;

  always #5 clk = ~clk;

  rr_ring_arbiter #(.N(N), .MAX_HOLD(MH)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .req       (req),
    .gnt       (gnt),
    .gnt_valid (gnt_valid),
    .gnt_id    (gnt_id),
    .timeout   (timeout)
  );

  function automatic int pick(input logic [N-1:0] r, input int base);
    int idx;
    for (int i = 0; i < N; i++) begin
      idx = (base + i) % N;
      if (r[idx]) return idx;
    end
    return -1;
  endfunction

  // Reference behaviour for one rising edge, from the sampled req/reset_n.
  task automatic model_edge();
    logic [N-1:0] r;
    bit rel, rev;
    if (!reset_n) begin
      m_owner = -1; m_ptr = 0; m_hold = 0; m_to = 1'b0;
    end else if (m_owner < 0) begin
      m_owner = pick(req, m_ptr); m_hold = 0; m_to = 1'b0;
    end else begin
      rel  = !req[m_owner];
      rev  = TO_EN && (m_hold == MH - 1) && req[m_owner];
      m_to = rev;
      if (rel || rev) begin
        m_ptr = (m_owner + 1) % N;
        r = req;
        r[m_owner] = 1'b0;
        m_owner = pick(r, m_ptr);
        m_hold = 0;
      end else begin
        m_hold++;
      end
    end
  endtask

  task automatic check_model(input string tag);
    logic [N-1:0] eg;
    logic [1:0]   ei;
    eg = (m_owner < 0) ? '0 : N'(1 << m_owner);
    ei = (m_owner < 0) ? 2'd0 : 2'(m_owner);
    checks++;
    assert (gnt === eg) else begin
      failures++; $error("FAIL %s gnt observed=%b expected=%b", tag, gnt, eg);
    end
    checks++;
    assert (gnt_valid === (m_owner >= 0)) else begin
      failures++; $error("FAIL %s gnt_valid observed=%b expected=%b", tag, gnt_valid, m_owner >= 0);
    end
    checks++;
    assert (gnt_id === ei) else begin
      failures++; $error("FAIL %s gnt_id observed=%0d expected=%0d", tag, gnt_id, ei);
    end
    checks++;
    assert (timeout === m_to) else begin
      failures++; $error("FAIL %s timeout observed=%b expected=%b", tag, timeout, m_to);
    end
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    check_model(tag);
  endtask

  task automatic expect_gnt(input string tag, input logic [N-1:0] e);
    checks++;
    assert (gnt === e) else begin
      failures++; $error("FAIL %s gnt observed=%b expected=%b", tag, gnt, e);
    end
  endtask

  task automatic expect_to(input string tag, input logic e);
    checks++;
    assert (timeout === e) else begin
      failures++; $error("FAIL %s timeout observed=%b expected=%b", tag, timeout, e);
    end
  endtask

  initial begin
    m_owner = -1; m_ptr = 0; m_hold = 0; m_to = 1'b0;

    // Reset held two cycles with all requesting
    reset_n = 1'b0; req = 4'b1111;
    step("reset0"); expect_gnt("reset0_const", 4'b0000);
    step("reset1"); expect_gnt("reset1_const", 4'b0000);
    reset_n = 1'b1;
    step("first_grant"); expect_gnt("first_grant_const", 4'b0001);

    // Rotation 0,1,2,3,0 with zero-bubble handover
    for (int k = 0; k < N; k++) begin
      step("rot_hold");
      step("rot_hold");
      req[k] = 1'b0;
      step("rot_handover");
      expect_gnt("rot_next", 4'(1 << ((k + 1) % N)));
      req[k] = 1'b1;
    end

    // Wrap-around after requester 2 finishes
    reset_n = 1'b0; step("wrap_rst");
    reset_n = 1'b1; req = 4'b0100; step("wrap_g2");
    req = 4'b0011; step("wrap"); expect_gnt("wrap_const", 4'b0001);

    // Single requester drop and re-raise
    reset_n = 1'b0; req = 4'b0000; step("single_rst");
    reset_n = 1'b1; req = 4'b0100;
    for (int i = 0; i < 4; i++) step("single_hi");
    expect_gnt("single_hi_const", 4'b0100);
    req = 4'b0000; step("single_lo"); expect_gnt("single_lo_const", 4'b0000);
    req = 4'b0100; step("single_again"); expect_gnt("single_again_const", 4'b0100);
    req = 4'b0011; step("single_ptr"); expect_gnt("single_ptr_const", 4'b0001);

    // Reset in the middle of a grant
    req = 4'b0000; step("mid_idle");
    req = 4'b0010; step("mid_g1"); expect_gnt("mid_g1_const", 4'b0010);
    req = 4'b0110; reset_n = 1'b0; step("mid_rst"); expect_gnt("mid_rst_const", 4'b0000);
    reset_n = 1'b1; step("mid_after"); expect_gnt("mid_after_const", 4'b0010);

    // Long hold: revoked after MAX_HOLD cycles when the timeout is built
    reset_n = 1'b0; step("to_rst");
    reset_n = 1'b1; req = 4'b0110; step("to_g1");
    for (int i = 0; i < MH - 1; i++) step("to_hold");
    expect_gnt("to_hold_const", 4'b0010);
    step("to_edge");
    expect_gnt("to_edge_const", TO_EN ? 4'b0100 : 4'b0010);
    expect_to("to_pulse", TO_EN);
    step("to_after"); expect_to("to_after_const", 1'b0);
    for (int i = 0; i < 2 * MH; i++) step("to_long");

    // Random traffic
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 3) == 0) req = 4'($urandom_range(0, 15));
      reset_n = ($urandom_range(0, 199) != 0);
      step("random");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
